// File: rtl/verinject_event_logger.sv
// Multi-channel injector-state monitor: decodes reset-marker and bit-injection events,
// timestamps them, and queues them in a first-word-fall-through FIFO with drop/event counters.
module verinject_event_logger #(
  parameter int CHANNELS       = 4,
  parameter int STATE_WIDTH    = 32,
  parameter int CYCLE_WIDTH    = 48,
  parameter int DEPTH          = 16,
  parameter int COUNT_WIDTH    = 16,
  parameter int ENABLE_DISPLAY = 0,
  localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [CYCLE_WIDTH-1:0]          cycle_number,
  input  logic [CHANNELS*STATE_WIDTH-1:0] verinject__injector_state,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [CW-1:0]                   out_channel,
  output logic [CYCLE_WIDTH-1:0]          out_cycle,
  output logic [STATE_WIDTH-1:0]          out_bit,
  output logic                            out_is_reset,
  output logic [COUNT_WIDTH-1:0]          event_count,
  output logic [COUNT_WIDTH-1:0]          drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [STATE_WIDTH-1:0] IDLE     = '1;
  localparam logic [STATE_WIDTH-1:0] RST_MARK = ~STATE_WIDTH'(1);

  logic [STATE_WIDTH-1:0] w_state [CHANNELS];
  logic [CHANNELS-1:0]    w_evt, w_mark, w_drained, w_drop;
  logic [COUNT_WIDTH:0]   w_drops, w_drop_sum;
  logic                   w_any, w_wr, w_rd;
  logic [CW-1:0]          w_sel;
  logic [AW:0]            w_count_next;

  logic [CHANNELS-1:0]    r_pend_valid, r_pend_reset;
  logic [STATE_WIDTH-1:0] r_pend_bit   [CHANNELS];
  logic [CYCLE_WIDTH-1:0] r_pend_cycle [CHANNELS];

  logic [CW-1:0]          r_mem_ch    [DEPTH];
  logic [CYCLE_WIDTH-1:0] r_mem_cycle [DEPTH];
  logic [STATE_WIDTH-1:0] r_mem_bit   [DEPTH];
  logic [DEPTH-1:0]       r_mem_reset;
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [AW:0]            r_count;
  logic                   r_full;

  // Decode, lowest-index drain arbitration and per-channel drop detection.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      w_state[c] = verinject__injector_state[c*STATE_WIDTH +: STATE_WIDTH];
      w_evt[c]   = (w_state[c] != IDLE);
      w_mark[c]  = (w_state[c] == RST_MARK);
      if (r_pend_valid[c]) begin
        w_any = 1'b1;
        w_sel = CW'(c);
      end
    end
  end

  assign w_wr = w_any && !r_full;
  assign w_rd = out_valid && out_ready;

  always_comb begin
    w_drops = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_drained[c] = w_wr && (w_sel == CW'(c));
      w_drop[c]    = w_evt[c] && r_pend_valid[c] && !w_drained[c];
      w_drops      = w_drops + {{COUNT_WIDTH{1'b0}}, w_drop[c]};
    end
  end

  assign w_drop_sum   = {1'b0, drop_count} + w_drops;
  assign w_count_next = r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};

  // NOTE: every clocked process uses <= so all registers update from the same pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend_valid <= '0;
      r_pend_reset <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_pend_bit[c]   <= '0;
        r_pend_cycle[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_evt[c] && (!r_pend_valid[c] || w_drained[c])) begin
          r_pend_valid[c] <= 1'b1;
          r_pend_reset[c] <= w_mark[c];
          r_pend_bit[c]   <= w_mark[c] ? '0 : w_state[c];
          r_pend_cycle[c] <= cycle_number;
        end else if (w_drained[c]) begin
          r_pend_valid[c] <= 1'b0;
        end
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are only observed through r_count.
  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem_ch[r_wptr]    <= w_sel;
      r_mem_cycle[r_wptr] <= r_pend_cycle[w_sel];
      r_mem_bit[r_wptr]   <= r_pend_bit[w_sel];
      r_mem_reset[r_wptr] <= r_pend_reset[w_sel];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      event_count <= '0;
      drop_count  <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_wr);
      r_rptr  <= r_rptr + AW'(w_rd);
      r_count <= w_count_next;
      r_full  <= (w_count_next == (AW+1)'(DEPTH));
      if (w_wr && (event_count != '1))
        event_count <= event_count + 1'b1;
      drop_count <= w_drop_sum[COUNT_WIDTH] ? '1 : w_drop_sum[COUNT_WIDTH-1:0];
    end
  end

  // Head fields read as zero while empty so reset and idle look identical downstream.
  assign out_valid    = (r_count != '0);
  assign out_channel  = out_valid ? r_mem_ch[r_rptr]    : '0;
  assign out_cycle    = out_valid ? r_mem_cycle[r_rptr] : '0;
  assign out_bit      = out_valid ? r_mem_bit[r_rptr]   : '0;
  assign out_is_reset = out_valid && r_mem_reset[r_rptr];

`ifndef SYNTHESIS
  if (ENABLE_DISPLAY != 0) begin : g_display
    always @(posedge clock) begin
      if (!reset && w_wr) begin
        if (r_pend_reset[w_sel])
          $display("verinject-reset ch %d", w_sel);
        else
          $display("verinject: ch %d at cycle %d injected into bit %d",
                   w_sel, r_pend_cycle[w_sel], r_pend_bit[w_sel]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_verinject_event_logger.sv
// Self-checking bench for verinject_event_logger: directed vector table, queue-based
// reference model under random traffic, and hand-built backpressure/collision/reset sequences.
module tb_verinject_event_logger;

  localparam int CH    = 4;
  localparam int SW    = 32;
  localparam int CYW   = 48;
  localparam int DEPTH = 16;
  localparam int CNTW  = 16;
  localparam int CW    = 2;
  localparam int unsigned MAXC = (1 << CNTW) - 1;
  localparam logic [SW-1:0] IDLE_W = 32'hFFFF_FFFF;
  localparam logic [SW-1:0] MARK_W = 32'hFFFF_FFFE;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [CYW-1:0]       cycle_number;
  logic [CH*SW-1:0]     inj_state;
  logic                 out_ready;
  logic                 out_valid;
  logic [CW-1:0]        out_channel;
  logic [CYW-1:0]       out_cycle;
  logic [SW-1:0]        out_bit;
  logic                 out_is_reset;
  logic [CNTW-1:0]      event_count;
  logic [CNTW-1:0]      drop_count;

  verinject_event_logger dut (
    .clock                    (clock),
    .reset                    (reset),
    .cycle_number             (cycle_number),
    .verinject__injector_state(inj_state),
    .out_ready                (out_ready),
    .out_valid                (out_valid),
    .out_channel              (out_channel),
    .out_cycle                (out_cycle),
    .out_bit                  (out_bit),
    .out_is_reset             (out_is_reset),
    .event_count              (event_count),
    .drop_count               (drop_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one pending slot per channel plus an ordered queue of logged events.
  typedef struct packed {
    logic            rst;
    logic [SW-1:0]   bitv;
    logic [CYW-1:0]  cyc;
    logic [CW-1:0]   ch;
  } ent_t;

  ent_t        pend   [CH];
  bit          pend_v [CH];
  ent_t        q [$];
  int unsigned m_ev, m_drop;

  task automatic model_clear();
    q.delete();
    m_ev   = 0;
    m_drop = 0;
    for (int c = 0; c < CH; c++) pend_v[c] = 1'b0;
  endtask

  task automatic model_edge();
    bit            full;
    bit            drained;
    logic [SW-1:0] w;
    full    = (q.size() == DEPTH);
    drained = 1'b0;
    if (q.size() > 0 && out_ready) void'(q.pop_front());
    if (!full) begin
      for (int c = 0; c < CH; c++) begin
        if (pend_v[c] && !drained) begin
          q.push_back(pend[c]);
          pend_v[c] = 1'b0;
          drained   = 1'b1;
          if (m_ev < MAXC) m_ev++;
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      w = inj_state[c*SW +: SW];
      if (w != IDLE_W) begin
        if (pend_v[c]) begin
          if (m_drop < MAXC) m_drop++;
        end else begin
          pend_v[c]    = 1'b1;
          pend[c].rst  = (w == MARK_W);
          pend[c].bitv = (w == MARK_W) ? '0 : w;
          pend[c].cyc  = cycle_number;
          pend[c].ch   = CW'(c);
        end
      end
    end
  endtask

  task automatic check_model();
    check("model valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("model channel", 64'(out_channel), 64'(q[0].ch));
      check("model cycle", 64'(out_cycle), 64'(q[0].cyc));
      check("model bit", 64'(out_bit), 64'(q[0].bitv));
      check("model is_reset", 64'(out_is_reset), 64'(q[0].rst));
    end
    check("model event_count", 64'(event_count), 64'(m_ev));
    check("model drop_count", 64'(drop_count), 64'(m_drop));
  endtask

  // Inputs change only at the falling edge; outputs are compared at the falling edge.
  task automatic step();
    @(posedge clock);
    if (!reset) model_edge();
    @(negedge clock);
    if (!reset) check_model();
    cycle_number = cycle_number + 1'b1;
  endtask

  task automatic set_idle();
    inj_state = '1;
  endtask

  task automatic set_ch(input int c, input logic [SW-1:0] v);
    inj_state[c*SW +: SW] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [CH*SW-1:0] mk(input logic [SW-1:0] c0, input logic [SW-1:0] c1,
                                          input logic [SW-1:0] c2, input logic [SW-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  typedef struct {
    logic [CH*SW-1:0] st;
    logic [CYW-1:0]   cyc;
    logic             rdy;
    logic             ev;
    logic [CW-1:0]    ech;
    logic [CYW-1:0]   ecyc;
    logic [SW-1:0]    ebit;
    logic             erst;
    logic [CNTW-1:0]  eev;
    logic [CNTW-1:0]  edrop;
  } vec_t;

  function automatic vec_t mkv(input logic [CH*SW-1:0] st, input int cyc, input logic ev,
                               input int ch, input int ecyc, input logic [SW-1:0] ebit,
                               input logic erst, input int eev);
    vec_t v;
    v.st = st; v.cyc = CYW'(cyc); v.rdy = 1'b1; v.ev = ev; v.ech = CW'(ch);
    v.ecyc = CYW'(ecyc); v.ebit = ebit; v.erst = erst; v.eev = CNTW'(eev); v.edrop = '0;
    return v;
  endfunction

  vec_t tbl [12];

  initial begin : main
    logic [CH*SW-1:0] idle_all;
    int               got;
    logic [SW-1:0]    last_bit;
    logic [CW-1:0]    last_ch;

    idle_all     = '1;
    reset        = 1'b1;
    inj_state    = '1;
    cycle_number = '0;
    out_ready    = 1'b0;

    tbl[0]  = mkv(idle_all,                                  99, 0, 0,   0,  0, 0, 0);
    tbl[1]  = mkv(mk(IDLE_W, 32'd5, IDLE_W, IDLE_W),        100, 0, 0,   0,  0, 0, 0);
    tbl[2]  = mkv(idle_all,                                 101, 1, 1, 100,  5, 0, 1);
    tbl[3]  = mkv(idle_all,                                 102, 0, 0,   0,  0, 0, 1);
    tbl[4]  = mkv(mk(MARK_W, IDLE_W, IDLE_W, IDLE_W),         7, 0, 0,   0,  0, 0, 1);
    tbl[5]  = mkv(idle_all,                                   8, 1, 0,   7,  0, 1, 2);
    tbl[6]  = mkv(idle_all,                                   9, 0, 0,   0,  0, 0, 2);
    tbl[7]  = mkv(mk(32'd3, IDLE_W, 32'd9, 32'd12),          20, 0, 0,   0,  0, 0, 2);
    tbl[8]  = mkv(idle_all,                                  21, 1, 0,  20,  3, 0, 3);
    tbl[9]  = mkv(idle_all,                                  22, 1, 2,  20,  9, 0, 4);
    tbl[10] = mkv(idle_all,                                  23, 1, 3,  20, 12, 0, 5);
    tbl[11] = mkv(idle_all,                                  24, 0, 0,   0,  0, 0, 5);

    @(negedge clock);
    do_reset();
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_channel", 64'(out_channel), 64'd0);
    check("reset out_cycle", 64'(out_cycle), 64'd0);
    check("reset out_bit", 64'(out_bit), 64'd0);
    check("reset out_is_reset", 64'(out_is_reset), 64'd0);
    check("reset event_count", 64'(event_count), 64'd0);
    check("reset drop_count", 64'(drop_count), 64'd0);

    // Directed table: single injection, reset marker, idle, simultaneous channels.
    for (int i = 0; i < 12; i++) begin
      inj_state    = tbl[i].st;
      cycle_number = tbl[i].cyc;
      out_ready    = tbl[i].rdy;
      step();
      check($sformatf("tbl%0d valid", i), 64'(out_valid), 64'(tbl[i].ev));
      check($sformatf("tbl%0d event_count", i), 64'(event_count), 64'(tbl[i].eev));
      check($sformatf("tbl%0d drop_count", i), 64'(drop_count), 64'(tbl[i].edrop));
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d channel", i), 64'(out_channel), 64'(tbl[i].ech));
        check($sformatf("tbl%0d cycle", i), 64'(out_cycle), 64'(tbl[i].ecyc));
        check($sformatf("tbl%0d bit", i), 64'(out_bit), 64'(tbl[i].ebit));
        check($sformatf("tbl%0d is_reset", i), 64'(out_is_reset), 64'(tbl[i].erst));
      end
    end
    set_idle();

    // Backpressure: 20 back-to-back events on ch0 with no reader.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_ch(0, SW'(i));
      step();
    end
    set_idle();
    check("bp event_count", 64'(event_count), 64'd16);
    check("bp drop_count", 64'(drop_count), 64'd3);
    out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 60 && got < 17; k++) begin
      if (out_valid) begin
        check("bp order", 64'(out_bit), 64'(got));
        got++;
      end
      step();
    end
    check("bp drained entries", 64'(got), 64'd17);
    check("bp empty after drain", 64'(out_valid), 64'd0);

    // Pending collision while the FIFO is full.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_ch(0, SW'(32'h10 + i));
      step();
    end
    set_idle();
    step();
    set_ch(1, 32'h100);
    step();
    set_ch(1, 32'h200);
    step();
    set_idle();
    check("col drop_count", 64'(drop_count), 64'd1);
    check("col event_count full", 64'(event_count), 64'd16);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("col no write on pop edge", 64'(event_count), 64'd16);
    step();
    check("col write after pop", 64'(event_count), 64'd17);
    out_ready = 1'b1;
    got      = 0;
    last_bit = '0;
    last_ch  = '0;
    for (int k = 0; k < 60 && out_valid; k++) begin
      last_bit = out_bit;
      last_ch  = out_channel;
      got++;
      step();
    end
    check("col entries", 64'(got), 64'd16);
    check("col last channel", 64'(last_ch), 64'd1);
    check("col last bit", 64'(last_bit), 64'h100);

    // Asynchronous reset between edges with entries buffered.
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      set_ch(2, SW'(i));
      step();
    end
    set_idle();
    step();
    check("mr event_count before", 64'(event_count), 64'd5);
    check("mr valid before", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b1;
    model_clear();
    set_ch(3, 32'h77);
    #1;
    check("mr async valid", 64'(out_valid), 64'd0);
    check("mr async channel", 64'(out_channel), 64'd0);
    check("mr async cycle", 64'(out_cycle), 64'd0);
    check("mr async bit", 64'(out_bit), 64'd0);
    check("mr async event_count", 64'(event_count), 64'd0);
    check("mr async drop_count", 64'(drop_count), 64'd0);
    @(posedge clock);
    @(negedge clock);
    check("mr ignored during reset", 64'(out_valid), 64'd0);
    reset = 1'b0;
    set_idle();
    set_ch(3, 32'h33);
    cycle_number = CYW'(500);
    step();
    set_idle();
    step();
    check("mr new valid", 64'(out_valid), 64'd1);
    check("mr new channel", 64'(out_channel), 64'd3);
    check("mr new cycle", 64'(out_cycle), 64'd500);
    check("mr new bit", 64'(out_bit), 64'h33);
    out_ready = 1'b1;
    step();
    check("mr no stale entries", 64'(out_valid), 64'd0);

    // Random traffic against the model, alternating light and heavy reader phases.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < CH; c++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 5)       set_ch(c, IDLE_W);
        else if (r == 5) set_ch(c, MARK_W);
        else             set_ch(c, $urandom);
      end
      if (((n / 100) % 2) == 0) out_ready = ($urandom_range(0, 9) < 2);
      else                      out_ready = ($urandom_range(0, 9) < 8);
      step();
    end
    set_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
